// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Also used by the D-stage stall logic to build its MDU hazard term.
package mdu_pkg;

   typedef logic [3:0] mdu_op_t;

   localparam mdu_op_t MDU_NONE  = 4'd0;
   localparam mdu_op_t MDU_MULT  = 4'd1;
   localparam mdu_op_t MDU_MULTU = 4'd2;
   localparam mdu_op_t MDU_DIV   = 4'd3;
   localparam mdu_op_t MDU_DIVU  = 4'd4;
   localparam mdu_op_t MDU_MFHI  = 4'd5;
   localparam mdu_op_t MDU_MFLO  = 4'd6;
   localparam mdu_op_t MDU_MTHI  = 4'd7;
   localparam mdu_op_t MDU_MTLO  = 4'd8;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   function automatic logic is_mdu_start(input mdu_op_t op);
      return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
   endfunction

   function automatic logic is_mdu_div(input mdu_op_t op);
      return op inside {MDU_DIV, MDU_DIVU};
   endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, fixed-latency mult/div,
// single-cycle MTHI/MTLO and combinational MFHI/MFLO read data.
module e_mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mdu_rd
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);

   logic [CW-1:0] cnt, cnt_nxt;
   mdu_op_t       op_q;
   logic [31:0]   a_q, b_q;
   logic [31:0]   hi_nxt, lo_nxt;
   logic          mt_we;

   logic [63:0]   prod_s, prod_u;
   logic          div_ovf;
   logic [31:0]   b_safe, q_s, r_s, q_u, r_u;

   assign busy  = (cnt != '0);
   assign start = valid & is_mdu_start(mdu_op) & ~busy;
   assign mt_we = valid & ~busy & (mdu_op inside {MDU_MTHI, MDU_MTLO});

   assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
   assign prod_u = {32'b0, a_q} * {32'b0, b_q};

   // Divisor forced to 1 for /0 and -2^31/-1: the /0 result is discarded,
   // and dividing by 1 yields exactly the required overflow result.
   assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
   assign b_safe  = ((b_q == '0) || div_ovf) ? 32'd1 : b_q;
   assign q_s     = $signed(a_q) / $signed(b_safe);
   assign r_s     = $signed(a_q) % $signed(b_safe);
   assign q_u     = a_q / b_safe;
   assign r_u     = a_q % b_safe;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         op_q <= MDU_NONE;
         a_q  <= '0;
         b_q  <= '0;
         hi   <= '0;
         lo   <= '0;
      end else begin
         cnt <= cnt_nxt;
         hi  <= hi_nxt;
         lo  <= lo_nxt;
         if (start) begin
            op_q <= mdu_op;
            a_q  <= src_a;
            b_q  <= src_b;
         end
      end
   end

   always_comb begin
      cnt_nxt = cnt;
      if (start)
         cnt_nxt = is_mdu_div(mdu_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      else if (busy)
         cnt_nxt = cnt - CW'(1);
   end

   always_comb begin
      hi_nxt = hi;
      lo_nxt = lo;
      if (cnt == CW'(1)) begin
         unique case (op_q)
            MDU_MULT:  {hi_nxt, lo_nxt} = prod_s;
            MDU_MULTU: {hi_nxt, lo_nxt} = prod_u;
            MDU_DIV: begin
               if (b_q != '0) begin
                  hi_nxt = r_s;
                  lo_nxt = q_s;
               end
            end
            MDU_DIVU: begin
               if (b_q != '0) begin
                  hi_nxt = r_u;
                  lo_nxt = q_u;
               end
            end
            default: ;
         endcase
      end else if (mt_we) begin
         if (mdu_op == MDU_MTHI)
            hi_nxt = src_a;
         else
            lo_nxt = src_a;
      end
   end

   always_comb begin
      mdu_rd = '0;
      unique case (1'b1)
         mdu_op == MDU_MFHI: mdu_rd = hi;
         mdu_op == MDU_MFLO: mdu_rd = lo;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_e_mdu.sv
// Randomized bench for e_mdu against an arithmetic HI/LO model,
// plus directed corner cases (div by zero, overflow, overlap, reset).
module tb_e_mdu;
   import mdu_pkg::*;

   localparam int NM = 5;
   localparam int ND = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid = 1'b0;
   logic [3:0]  mdu_op = MDU_NONE;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        start, busy;
   logic [31:0] hi, lo, mdu_rd;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   e_mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
      .clk(clk), .reset(reset), .valid(valid), .mdu_op(mdu_op),
      .src_a(src_a), .src_b(src_b), .start(start), .busy(busy),
      .hi(hi), .lo(lo), .mdu_rd(mdu_rd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // HI/LO effect of one accepted operation, from plain integer arithmetic
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      longint unsigned ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         MDU_MULT: begin
            p = sa * sb;
            {m_hi, m_lo} = p;
         end
         MDU_MULTU: begin
            p = ua * ub;
            {m_hi, m_lo} = p;
         end
         MDU_DIV: if (b != 0) begin
            q = sa / sb;
            r = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
         end
         MDU_DIVU: if (b != 0) begin
            m_lo = a / b;
            m_hi = a % b;
         end
         MDU_MTHI: m_hi = a;
         MDU_MTLO: m_lo = a;
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] pick(input bit allow_zero);
      case ($urandom_range(0, 6))
         0: return allow_zero ? 32'h0 : 32'h3;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   // Called #1 after the accept edge; scrambles operands while busy
   task automatic finish_op(input int n, input string tag,
                            input logic [31:0] old_hi, input logic [31:0] old_lo);
      int k;
      k = 0;
      valid = 1'b0;
      mdu_op = MDU_NONE;
      while (busy === 1'b1 && k < 64) begin
         k++;
         if (k == n) begin
            chk({tag, "_hold_hi"}, hi, old_hi);
            chk({tag, "_hold_lo"}, lo, old_lo);
         end
         src_a = $urandom;
         src_b = $urandom;
         @(posedge clk); #1;
      end
      chk({tag, "_busy_len"}, k, n);
      chk({tag, "_hi"}, hi, m_hi);
      chk({tag, "_lo"}, lo, m_lo);
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
      logic [31:0] oh, ol;
      valid = 1'b1;
      mdu_op = op;
      src_a = a;
      src_b = b;
      #1;
      chk({tag, "_start"}, start, 1);
      oh = m_hi;
      ol = m_lo;
      model(op, a, b);
      @(posedge clk); #1;
      finish_op(is_mdu_div(op) ? ND : NM, tag, oh, ol);
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] v, input string tag);
      valid = 1'b1;
      mdu_op = op;
      src_a = v;
      src_b = $urandom;
      #1;
      chk({tag, "_start"}, start, 0);
      model(op, v, 32'h0);
      @(posedge clk); #1;
      chk({tag, "_busy"}, busy, 0);
      valid = 1'b0;
      mdu_op = MDU_NONE;
   endtask

   task automatic mf(input logic [3:0] op, input string tag);
      valid = 1'b1;
      mdu_op = op;
      #1;
      chk(tag, mdu_rd, (op == MDU_MFHI) ? m_hi : m_lo);
      @(posedge clk); #1;
      valid = 1'b0;
      mdu_op = MDU_NONE;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] a, b, oh, ol;
      logic [3:0]  op;
      int k;

      #2;
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd", mdu_rd, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd5, "mult");
      chk("mult_hi_k", hi, 32'hFFFF_FFFF);
      chk("mult_lo_k", lo, 32'hFFFF_FFF1);
      run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
      chk("multu_hi_k", hi, 32'h1);
      chk("multu_lo_k", lo, 32'hFFFF_FFFE);
      run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, "div");
      chk("div_lo_k", lo, 32'hFFFF_FFFD);
      chk("div_hi_k", hi, 32'hFFFF_FFFF);

      mt(MDU_MTHI, 32'h1234, "mthi");
      mt(MDU_MTLO, 32'h5678, "mtlo");
      run_op(MDU_DIVU, 32'd7, 32'd0, "divz");
      chk("divz_hi_k", hi, 32'h1234);
      chk("divz_lo_k", lo, 32'h5678);
      run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "dovf");
      chk("dovf_lo_k", lo, 32'h8000_0000);
      chk("dovf_hi_k", hi, 32'h0);

      mt(MDU_MTHI, 32'hCAFE_BABE, "mthi2");
      mf(MDU_MFHI, "mfhi");
      chk("mfhi_k", hi, 32'hCAFE_BABE);
      mf(MDU_MFLO, "mflo");
      mdu_op = MDU_NONE;
      #1;
      chk("rd_none", mdu_rd, 0);

      // DIV in flight, operands churn, MULT presented from busy cycle 3
      valid = 1'b1;
      mdu_op = MDU_DIV;
      src_a = 32'hFFFF_FF9C;
      src_b = 32'd7;
      #1;
      chk("ovl_start", start, 1);
      oh = m_hi;
      ol = m_lo;
      model(MDU_DIV, src_a, src_b);
      @(posedge clk); #1;
      k = 0;
      while (busy === 1'b1 && k < 64) begin
         k++;
         valid = (k >= 3);
         mdu_op = (k >= 3) ? MDU_MULT : MDU_NONE;
         src_a = $urandom;
         src_b = $urandom;
         #1;
         chk("ovl_nostart", start, 0);
         if (k == ND) begin
            chk("ovl_hold_hi", hi, oh);
            chk("ovl_hold_lo", lo, ol);
         end
         @(posedge clk); #1;
      end
      chk("ovl_busy_len", k, ND);
      chk("ovl_hi", hi, 32'hFFFF_FFFE);
      chk("ovl_lo", lo, 32'hFFFF_FFF2);
      #1;
      chk("ovl_next_start", start, 1);
      oh = m_hi;
      ol = m_lo;
      model(MDU_MULT, src_a, src_b);
      @(posedge clk); #1;
      finish_op(NM, "ovl_mult", oh, ol);

      // Reset in the middle of busy cycle 3
      run_op(MDU_MULTU, 32'h0001_0003, 32'h0002_0005, "pre_rst");
      valid = 1'b1;
      mdu_op = MDU_MULT;
      src_a = 32'h0123_4567;
      src_b = 32'h89;
      @(posedge clk); #1;
      valid = 1'b0;
      mdu_op = MDU_NONE;
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_hi", hi, 0);
      chk("arst_lo", lo, 0);
      @(posedge clk); #3;
      reset = 1'b0;
      m_hi = '0;
      m_lo = '0;
      repeat (NM + 2) @(posedge clk);
      #1;
      chk("post_rst_hi", hi, 0);
      chk("post_rst_lo", lo, 0);
      chk("post_rst_busy", busy, 0);

      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(1, 8));
         a = pick(1'b1);
         b = pick(1'b1);
         case (op)
            MDU_MFHI, MDU_MFLO: mf(op, "r_mf");
            MDU_MTHI, MDU_MTLO: mt(op, a, "r_mt");
            default: run_op(op, a, b, "r_op");
         endcase
      end
      mf(MDU_MFHI, "end_mfhi");
      mf(MDU_MFLO, "end_mflo");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
